// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter: edge-captured pending interrupts, masked highest-index selection, valid/ready delivery
module irq_pending_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq_in,
    input  logic [7:0] irq_mask,
    input  logic       out_ready,
    input  logic       lost_clr,
    output logic [2:0] out_idx,
    output logic       out_valid,
    output logic [7:0] pending,
    output logic [7:0] lost_flag
);
    typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;
    state_t     state_q, state_d;
    logic [7:0] irq_prev_q, irq_prev_d, pending_q, pending_d, lost_q, lost_d;
    logic [7:0] irq_edge, cand, load_vec;
    logic [2:0] out_idx_q, out_idx_d, sel;
    logic       load;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            irq_prev_q <= '0;
            pending_q  <= '0;
            lost_q     <= '0;
            out_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            lost_q     <= lost_d;
            out_idx_q  <= out_idx_d;
        end
    end
    // highest set bit wins because later iterations overwrite
    always_comb begin
        sel = 3'd0;
        for (int i = 0; i < 8; i++)
            if (cand[i]) sel = 3'(i);
    end
    always_comb begin
        irq_edge   = irq_in & ~irq_prev_q;
        cand       = pending_q & ~irq_mask;
        load       = |cand && (state_q == IDLE || out_ready);
        load_vec   = load ? 8'd1 << sel : 8'd0;
        irq_prev_d = irq_in;
        pending_d  = irq_edge | (pending_q & ~load_vec);
        lost_d     = (lost_clr ? 8'd0 : lost_q) | (irq_edge & pending_q & ~load_vec);
        out_idx_d  = load ? sel : out_idx_q;
    end
    always_comb begin
        state_d = load ? PRESENT : (state_q == PRESENT && !out_ready) ? PRESENT : IDLE;
    end
    always_comb begin
        out_valid = state_q == PRESENT;
        out_idx   = out_idx_q;
        pending   = pending_q;
        lost_flag = lost_q;
    end
endmodule
